// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle main controller: opcode encodings,
// ALUOp codes, the controller state enum and the opcode legality check.
// Optional feature macro: BRANCH_EN (branch opcode becomes legal).
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_I    = 2'b00;
    localparam logic [1:0] ALUOP_LDST = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b10;
    localparam logic [1:0] ALUOP_BR   = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        FAULT  = 3'd6
    } state_t;

    // True for opcodes the controller knows how to sequence.
    function automatic logic isLegalOp(input logic [6:0] op);
        logic legal;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE: legal = 1'b1;
`ifdef BRANCH_EN
            OP_BRANCH:                     legal = 1'b1;
`endif
            default:                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Handshake and control bundle between the multi-cycle controller (master)
// and the datapath / memories (slave).
// Optional feature macro: BRANCH_EN (adds the branch strobe).
interface multicycle_ctrl_fsm_if #(
    parameter int OPCODE_W = 7,
    parameter int ALUOP_W  = 2,
    parameter int RETIRE_W = 16
);
    logic                run;
    logic [OPCODE_W-1:0] opcode;
    logic                imem_ready;
    logic                dmem_ready;
    logic                fault_clr;
    logic                imem_req;
    logic                dmem_req;
    logic                pc_write;
    logic                ir_write;
    logic                alu_src;
    logic                mem_to_reg;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic [ALUOP_W-1:0]  alu_op;
    logic                instr_done;
    logic                fault;
    logic [RETIRE_W-1:0] retire_cnt;
`ifdef BRANCH_EN
    logic                branch;
`endif

    modport master (
        input  run, opcode, imem_ready, dmem_ready, fault_clr,
        output imem_req, dmem_req, pc_write, ir_write, alu_src, mem_to_reg,
               reg_write, mem_read, mem_write, alu_op, instr_done, fault,
               retire_cnt
`ifdef BRANCH_EN
               , branch
`endif
    );

    modport slave (
        output run, opcode, imem_ready, dmem_ready, fault_clr,
        input  imem_req, dmem_req, pc_write, ir_write, alu_src, mem_to_reg,
               reg_write, mem_read, mem_write, alu_op, instr_done, fault,
               retire_cnt
`ifdef BRANCH_EN
               , branch
`endif
    );

endinterface

// File: rtl/multicycle_ctrl_fsm_wait_timer.sv
// Memory wait timer shared by FETCH and MEM: counts consecutive cycles spent
// waiting without ready and flags a timeout when the limit is reached while
// ready is still low. A limit of 0 disables the timeout.
module multicycle_ctrl_fsm_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic ready,
    output logic timeout
);
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] waitCnt_r;
    logic [CNT_W-1:0] waitCntNext_s;

    // Count stalled cycles; any ready or non-waiting cycle rearms the counter.
    always_comb begin
        waitCntNext_s = '0;
        if (waiting && !ready) begin
            waitCntNext_s = waitCnt_r + CNT_W'(1);
        end else begin
            waitCntNext_s = '0;
        end
    end

    // Timeout only when still stalled at the limit; ready in that cycle wins.
    always_comb begin
        timeout = 1'b0;
        if ((MEM_TIMEOUT != 0) && waiting && !ready &&
            (waitCnt_r == CNT_W'(MEM_TIMEOUT))) begin
            timeout = 1'b1;
        end else begin
            timeout = 1'b0;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt_r <= '0;
        end else begin
            waitCnt_r <= waitCntNext_s;
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle main controller: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB, handshakes with instruction and data memory,
// traps illegal opcodes and memory timeouts into a sticky FAULT state and
// counts retired instructions. Outputs depend only on state and latched opcode
// (plus the memory ready that completes the current access).
// Optional feature macro: BRANCH_EN (branch opcode retires from EXEC).
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 7,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int RETIRE_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_ctrl_fsm_if.master bus
);
    state_t              state_r;
    state_t              stateNext_s;
    logic [OPCODE_W-1:0] opQ_r;
    logic [RETIRE_W-1:0] retireCnt_r;
    logic [6:0]          opSel_s;
    logic                isLoad_s;
    logic                isStore_s;
    logic                retire_s;
    logic                waiting_s;
    logic                ready_s;
    logic                timeout_s;
    logic                imemReq_s;
    logic                dmemReq_s;
    logic                pcWrite_s;
    logic                irWrite_s;
    logic                aluSrc_s;
    logic                memToReg_s;
    logic                regWrite_s;
    logic                memRead_s;
    logic                memWrite_s;
    logic [1:0]          aluOp_s;
    logic                fault_s;
`ifdef BRANCH_EN
    logic                branch_s;
`endif

    assign opSel_s   = 7'(opQ_r);
    assign isLoad_s  = (opSel_s == OP_LOAD);
    assign isStore_s = (opSel_s == OP_STORE);

    // Select which memory the shared wait timer is watching.
    always_comb begin
        waiting_s = 1'b0;
        ready_s   = 1'b0;
        if (state_r == FETCH) begin
            waiting_s = 1'b1;
            ready_s   = bus.imem_ready;
        end else if (state_r == MEM) begin
            waiting_s = 1'b1;
            ready_s   = bus.dmem_ready;
        end else begin
            waiting_s = 1'b0;
            ready_s   = 1'b0;
        end
    end

    multicycle_ctrl_fsm_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_waitTimer (
        .clk     (clk),
        .rst_n   (rst_n),
        .waiting (waiting_s),
        .ready   (ready_s),
        .timeout (timeout_s)
    );

    // Next-state and control decode from state and latched opcode.
    always_comb begin
        stateNext_s = state_r;
        retire_s    = 1'b0;
        imemReq_s   = 1'b0;
        dmemReq_s   = 1'b0;
        pcWrite_s   = 1'b0;
        irWrite_s   = 1'b0;
        aluSrc_s    = 1'b0;
        memToReg_s  = 1'b0;
        regWrite_s  = 1'b0;
        memRead_s   = 1'b0;
        memWrite_s  = 1'b0;
        aluOp_s     = 2'b00;
        fault_s     = 1'b0;
`ifdef BRANCH_EN
        branch_s    = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (bus.run) begin
                    stateNext_s = FETCH;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            FETCH: begin
                imemReq_s = 1'b1;
                if (bus.imem_ready) begin
                    irWrite_s   = 1'b1;
                    pcWrite_s   = 1'b1;
                    stateNext_s = DECODE;
                end else if (timeout_s) begin
                    stateNext_s = FAULT;
                end else begin
                    stateNext_s = FETCH;
                end
            end
            DECODE: begin
                if (isLegalOp(7'(bus.opcode))) begin
                    stateNext_s = EXEC;
                end else begin
                    stateNext_s = FAULT;
                end
            end
            EXEC: begin
                case (opSel_s)
                    OP_R: begin
                        aluOp_s     = ALUOP_R;
                        stateNext_s = WB;
                    end
                    OP_I: begin
                        aluOp_s     = ALUOP_I;
                        aluSrc_s    = 1'b1;
                        stateNext_s = WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        aluOp_s     = ALUOP_LDST;
                        aluSrc_s    = 1'b1;
                        stateNext_s = MEM;
                    end
`ifdef BRANCH_EN
                    OP_BRANCH: begin
                        aluOp_s     = ALUOP_BR;
                        branch_s    = 1'b1;
                        retire_s    = 1'b1;
                        stateNext_s = bus.run ? FETCH : IDLE;
                    end
`endif
                    default: begin
                        stateNext_s = FAULT;
                    end
                endcase
            end
            MEM: begin
                dmemReq_s  = 1'b1;
                memRead_s  = isLoad_s;
                memWrite_s = isStore_s;
                if (bus.dmem_ready) begin
                    if (isLoad_s) begin
                        stateNext_s = WB;
                    end else begin
                        retire_s    = 1'b1;
                        stateNext_s = bus.run ? FETCH : IDLE;
                    end
                end else if (timeout_s) begin
                    stateNext_s = FAULT;
                end else begin
                    stateNext_s = MEM;
                end
            end
            WB: begin
                regWrite_s  = 1'b1;
                memToReg_s  = isLoad_s;
                retire_s    = 1'b1;
                stateNext_s = bus.run ? FETCH : IDLE;
            end
            FAULT: begin
                fault_s = 1'b1;
                if (bus.fault_clr) begin
                    stateNext_s = IDLE;
                end else begin
                    stateNext_s = FAULT;
                end
            end
            default: begin
                stateNext_s = IDLE;
            end
        endcase
    end

    // State, latched opcode (kept through FAULT for debug) and retire count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            opQ_r       <= '0;
            retireCnt_r <= '0;
        end else begin
            state_r <= stateNext_s;
            if (state_r == DECODE) begin
                opQ_r <= bus.opcode;
            end
            if (retire_s) begin
                retireCnt_r <= retireCnt_r + RETIRE_W'(1);
            end
        end
    end

    assign bus.imem_req   = imemReq_s;
    assign bus.dmem_req   = dmemReq_s;
    assign bus.pc_write   = pcWrite_s;
    assign bus.ir_write   = irWrite_s;
    assign bus.alu_src    = aluSrc_s;
    assign bus.mem_to_reg = memToReg_s;
    assign bus.reg_write  = regWrite_s;
    assign bus.mem_read   = memRead_s;
    assign bus.mem_write  = memWrite_s;
    assign bus.alu_op     = ALUOP_W'(aluOp_s);
    assign bus.instr_done = retire_s;
    assign bus.fault      = fault_s;
    assign bus.retire_cnt = retireCnt_r;
`ifdef BRANCH_EN
    assign bus.branch     = branch_s;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: a per-cycle vector table for
// R/I/load/store sequencing, hand-written sequences for illegal opcodes,
// fetch timeout, ready-at-limit and async reset, plus a retire scoreboard.
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_BAD = 7'b1111111;

    // {imem_req,dmem_req,pc_write,ir_write,alu_src,mem_to_reg,reg_write,
    //  mem_read,mem_write,alu_op[1:0],instr_done,fault}
    localparam logic [12:0] O_IDLE   = 13'b0_0_0_0_0_0_0_0_0_00_0_0;
    localparam logic [12:0] O_FWAIT  = 13'b1_0_0_0_0_0_0_0_0_00_0_0;
    localparam logic [12:0] O_FGO    = 13'b1_0_1_1_0_0_0_0_0_00_0_0;
    localparam logic [12:0] O_EXR    = 13'b0_0_0_0_0_0_0_0_0_10_0_0;
    localparam logic [12:0] O_EXI    = 13'b0_0_0_0_1_0_0_0_0_00_0_0;
    localparam logic [12:0] O_EXLS   = 13'b0_0_0_0_1_0_0_0_0_01_0_0;
    localparam logic [12:0] O_WBALU  = 13'b0_0_0_0_0_0_1_0_0_00_1_0;
    localparam logic [12:0] O_MEMLD  = 13'b0_1_0_0_0_0_0_1_0_00_0_0;
    localparam logic [12:0] O_WBLD   = 13'b0_0_0_0_0_1_1_0_0_00_1_0;
    localparam logic [12:0] O_STDONE = 13'b0_1_0_0_0_0_0_0_1_00_1_0;
    localparam logic [12:0] O_FAULT  = 13'b0_0_0_0_0_0_0_0_0_00_0_1;
    localparam logic [12:0] O_EXBR   = 13'b0_0_0_0_0_0_0_0_0_11_1_0;

    typedef struct {
        string       name;
        logic        run;
        logic [6:0]  opc;
        logic        iRdy;
        logic        dRdy;
        logic        fClr;
        logic        launch;
        logic [12:0] expOut;
        logic [15:0] expRet;
    } vec_t;

    logic        clk;
    logic        rst_n;
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] expRetQ[$];
    logic [15:0] modelRet = 16'd0;
    vec_t        vecs[$];
    logic [12:0] outV;

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign outV = {bus.imem_req, bus.dmem_req, bus.pc_write, bus.ir_write,
                   bus.alu_src, bus.mem_to_reg, bus.reg_write, bus.mem_read,
                   bus.mem_write, bus.alu_op, bus.instr_done, bus.fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic r, input logic [6:0] o,
                                input logic i, input logic d, input logic f,
                                input logic l, input logic [12:0] e, input logic [15:0] rc);
        vec_t v;
        v.name = n; v.run = r; v.opc = o; v.iRdy = i; v.dRdy = d; v.fClr = f;
        v.launch = l; v.expOut = e; v.expRet = rc;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [6:0] o, input logic i,
                         input logic d, input logic f);
        bus.run        = r;
        bus.opcode     = o;
        bus.imem_ready = i;
        bus.dmem_ready = d;
        bus.fault_clr  = f;
    endtask

    // Expected retire count for an instruction entering DECODE legally.
    task automatic launch();
        expRetQ.push_back(modelRet);
        modelRet = modelRet + 16'd1;
    endtask

    task automatic stepChk(input string nm, input logic r, input logic [6:0] o,
                           input logic i, input logic d, input logic f,
                           input logic [12:0] e);
        @(posedge clk);
        #1;
        drive(r, o, i, d, f);
        #1;
        chk(nm, 32'(outV), 32'(e));
    endtask

    // Scoreboard: every retire pulse must match the oldest launched instruction.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.instr_done === 1'b1) begin
            if (expRetQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_done: got instr_done=1 expected none pending");
            end else begin
                chk("sb_retire_cnt", 32'(bus.retire_cnt), 32'(expRetQ.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        #3;
        chk("reset_outputs", 32'(outV), 32'(O_IDLE));
        chk("reset_retire", 32'(bus.retire_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // name, run, opcode, imem_ready, dmem_ready, fault_clr, launch, outputs, retire_cnt
        vecs.push_back(mk("idle_hold",  1'b0, OPC_R,   1'b0, 1'b0, 1'b0, 1'b0, O_IDLE,   16'd0));
        vecs.push_back(mk("idle_run",   1'b1, OPC_R,   1'b0, 1'b0, 1'b0, 1'b0, O_IDLE,   16'd0));
        vecs.push_back(mk("r_fetch",    1'b1, OPC_R,   1'b1, 1'b0, 1'b0, 1'b0, O_FGO,    16'd0));
        vecs.push_back(mk("r_decode",   1'b1, OPC_R,   1'b0, 1'b0, 1'b0, 1'b1, O_IDLE,   16'd0));
        vecs.push_back(mk("r_exec",     1'b1, OPC_BAD, 1'b0, 1'b0, 1'b0, 1'b0, O_EXR,    16'd0));
        vecs.push_back(mk("r_wb",       1'b1, OPC_BAD, 1'b0, 1'b0, 1'b0, 1'b0, O_WBALU,  16'd0));
        vecs.push_back(mk("i_fetch",    1'b1, OPC_I,   1'b1, 1'b0, 1'b0, 1'b0, O_FGO,    16'd1));
        vecs.push_back(mk("i_decode",   1'b1, OPC_I,   1'b0, 1'b0, 1'b0, 1'b1, O_IDLE,   16'd1));
        vecs.push_back(mk("i_exec",     1'b1, OPC_R,   1'b0, 1'b0, 1'b0, 1'b0, O_EXI,    16'd1));
        vecs.push_back(mk("i_wb",       1'b1, OPC_R,   1'b0, 1'b0, 1'b0, 1'b0, O_WBALU,  16'd1));
        vecs.push_back(mk("ld_fwait1",  1'b1, OPC_LD,  1'b0, 1'b0, 1'b0, 1'b0, O_FWAIT,  16'd2));
        vecs.push_back(mk("ld_fwait2",  1'b1, OPC_LD,  1'b0, 1'b0, 1'b0, 1'b0, O_FWAIT,  16'd2));
        vecs.push_back(mk("ld_fetch",   1'b1, OPC_LD,  1'b1, 1'b0, 1'b0, 1'b0, O_FGO,    16'd2));
        vecs.push_back(mk("ld_decode",  1'b1, OPC_LD,  1'b0, 1'b0, 1'b0, 1'b1, O_IDLE,   16'd2));
        vecs.push_back(mk("ld_exec",    1'b1, OPC_ST,  1'b0, 1'b0, 1'b0, 1'b0, O_EXLS,   16'd2));
        vecs.push_back(mk("ld_mem1",    1'b1, OPC_ST,  1'b0, 1'b0, 1'b0, 1'b0, O_MEMLD,  16'd2));
        vecs.push_back(mk("ld_mem2",    1'b1, OPC_ST,  1'b0, 1'b0, 1'b0, 1'b0, O_MEMLD,  16'd2));
        vecs.push_back(mk("ld_mem3",    1'b1, OPC_ST,  1'b0, 1'b0, 1'b0, 1'b0, O_MEMLD,  16'd2));
        vecs.push_back(mk("ld_mem4",    1'b1, OPC_ST,  1'b0, 1'b1, 1'b0, 1'b0, O_MEMLD,  16'd2));
        vecs.push_back(mk("ld_wb",      1'b1, OPC_ST,  1'b0, 1'b0, 1'b0, 1'b0, O_WBLD,   16'd2));
        vecs.push_back(mk("st_fetch",   1'b1, OPC_ST,  1'b1, 1'b0, 1'b0, 1'b0, O_FGO,    16'd3));
        vecs.push_back(mk("st_decode",  1'b1, OPC_ST,  1'b0, 1'b0, 1'b0, 1'b1, O_IDLE,   16'd3));
        vecs.push_back(mk("st_exec",    1'b1, OPC_LD,  1'b0, 1'b0, 1'b0, 1'b0, O_EXLS,   16'd3));
        vecs.push_back(mk("st_mem",     1'b0, OPC_LD,  1'b0, 1'b1, 1'b0, 1'b0, O_STDONE, 16'd3));
        vecs.push_back(mk("st_idle1",   1'b0, OPC_LD,  1'b1, 1'b1, 1'b0, 1'b0, O_IDLE,   16'd4));
        vecs.push_back(mk("st_idle2",   1'b0, OPC_LD,  1'b1, 1'b1, 1'b0, 1'b0, O_IDLE,   16'd4));

        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk);
            #1;
            drive(vecs[k].run, vecs[k].opc, vecs[k].iRdy, vecs[k].dRdy, vecs[k].fClr);
            if (vecs[k].launch) begin
                launch();
            end
            #1;
            chk({vecs[k].name, "_out"}, 32'(outV), 32'(vecs[k].expOut));
            chk({vecs[k].name, "_ret"}, 32'(bus.retire_cnt), 32'(vecs[k].expRet));
        end

        // Illegal opcode traps into a sticky FAULT until fault_clr.
        stepChk("ill_idle",    1'b1, OPC_BAD, 1'b1, 1'b0, 1'b0, O_IDLE);
        stepChk("ill_fetch",   1'b1, OPC_BAD, 1'b1, 1'b0, 1'b0, O_FGO);
        stepChk("ill_decode",  1'b1, OPC_BAD, 1'b1, 1'b0, 1'b0, O_IDLE);
        stepChk("ill_fault1",  1'b1, OPC_R,   1'b1, 1'b1, 1'b0, O_FAULT);
        stepChk("ill_fault2",  1'b1, OPC_R,   1'b1, 1'b1, 1'b0, O_FAULT);
        stepChk("ill_clr",     1'b0, OPC_R,   1'b0, 1'b0, 1'b1, O_FAULT);
        stepChk("ill_idle2",   1'b0, OPC_R,   1'b0, 1'b0, 1'b0, O_IDLE);
        stepChk("ill_idle3",   1'b0, OPC_R,   1'b0, 1'b0, 1'b0, O_IDLE);
        chk("ill_retire", 32'(bus.retire_cnt), 32'd4);

`ifndef BRANCH_EN
        // Branch opcode is illegal without the branch option.
        stepChk("br_idle",     1'b1, OPC_BR,  1'b1, 1'b0, 1'b0, O_IDLE);
        stepChk("br_fetch",    1'b1, OPC_BR,  1'b1, 1'b0, 1'b0, O_FGO);
        stepChk("br_decode",   1'b1, OPC_BR,  1'b0, 1'b0, 1'b0, O_IDLE);
        stepChk("br_fault",    1'b0, OPC_BR,  1'b0, 1'b0, 1'b1, O_FAULT);
        stepChk("br_cleared",  1'b0, OPC_BR,  1'b0, 1'b0, 1'b0, O_IDLE);
`else
        // Branch retires straight from EXEC with alu_op=11.
        stepChk("br_idle",     1'b1, OPC_BR,  1'b1, 1'b0, 1'b0, O_IDLE);
        stepChk("br_fetch",    1'b1, OPC_BR,  1'b1, 1'b0, 1'b0, O_FGO);
        stepChk("br_decode",   1'b1, OPC_BR,  1'b0, 1'b0, 1'b0, O_IDLE);
        launch();
        stepChk("br_exec",     1'b0, OPC_R,   1'b0, 1'b0, 1'b0, O_EXBR);
        chk("br_branch", 32'(bus.branch), 32'd1);
        stepChk("br_idle2",    1'b0, OPC_R,   1'b0, 1'b0, 1'b0, O_IDLE);
`endif

        // Fetch stalled for 16 cycles hits the limit and faults.
        stepChk("to_idle",     1'b1, OPC_R,   1'b0, 1'b0, 1'b0, O_IDLE);
        for (int k = 1; k <= 16; k++) begin
            stepChk($sformatf("to_wait%0d", k), 1'b1, OPC_R, 1'b0, 1'b0, 1'b0, O_FWAIT);
        end
        stepChk("to_fault",    1'b0, OPC_R,   1'b0, 1'b0, 1'b0, O_FAULT);
        stepChk("to_clr",      1'b0, OPC_R,   1'b0, 1'b0, 1'b1, O_FAULT);

        // Ready arriving in the 16th cycle wins over the timeout.
        stepChk("rdy_idle",    1'b1, OPC_R,   1'b0, 1'b0, 1'b0, O_IDLE);
        for (int k = 1; k <= 15; k++) begin
            stepChk($sformatf("rdy_wait%0d", k), 1'b1, OPC_R, 1'b0, 1'b0, 1'b0, O_FWAIT);
        end
        stepChk("rdy_fetch16", 1'b1, OPC_R,   1'b1, 1'b0, 1'b0, O_FGO);
        launch();
        stepChk("rdy_decode",  1'b1, OPC_R,   1'b0, 1'b0, 1'b0, O_IDLE);
        stepChk("rdy_exec",    1'b1, OPC_R,   1'b0, 1'b0, 1'b0, O_EXR);
        stepChk("rdy_wb",      1'b1, OPC_R,   1'b0, 1'b0, 1'b0, O_WBALU);

        // Async reset while a load waits in MEM.
        stepChk("rst_fetch",   1'b1, OPC_LD,  1'b1, 1'b0, 1'b0, O_FGO);
        launch();
        stepChk("rst_decode",  1'b1, OPC_LD,  1'b0, 1'b0, 1'b0, O_IDLE);
        stepChk("rst_exec",    1'b1, OPC_LD,  1'b0, 1'b0, 1'b0, O_EXLS);
        stepChk("rst_mem",     1'b1, OPC_LD,  1'b0, 1'b0, 1'b0, O_MEMLD);
`ifdef BRANCH_EN
        chk("rst_pre_retire", 32'(bus.retire_cnt), 32'd6);
`else
        chk("rst_pre_retire", 32'(bus.retire_cnt), 32'd5);
`endif
        rst_n = 1'b0;
        #1;
        chk("rst_async_out", 32'(outV), 32'(O_IDLE));
        chk("rst_async_ret", 32'(bus.retire_cnt), 32'd0);
        expRetQ.delete();
        modelRet = 16'd0;
        @(posedge clk);
        #1;
        chk("rst_held_out", 32'(outV), 32'(O_IDLE));
        rst_n = 1'b1;
        drive(1'b1, OPC_R, 1'b0, 1'b0, 1'b0);
        stepChk("post_fetch",  1'b1, OPC_R,   1'b1, 1'b0, 1'b0, O_FGO);
        launch();
        stepChk("post_decode", 1'b1, OPC_R,   1'b0, 1'b0, 1'b0, O_IDLE);
        stepChk("post_exec",   1'b1, OPC_R,   1'b0, 1'b0, 1'b0, O_EXR);
        stepChk("post_wb",     1'b0, OPC_R,   1'b0, 1'b0, 1'b0, O_WBALU);
        stepChk("post_idle",   1'b0, OPC_R,   1'b0, 1'b0, 1'b0, O_IDLE);
        chk("post_retire", 32'(bus.retire_cnt), 32'd1);

        @(posedge clk);
        #1;
        chk("sb_drained", 32'(expRetQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
